// File: rtl/enemy_manager.sv
// enemy_manager: central scheduler for the enemy slots.
// Owns life state, hit points and respawn timers per slot, and merges the
// per-slot attack requests into one rate-limited player damage event.
// Optional build macro: ENEMY_RESPAWN_SCALE_EN (respawn delay shrinks with kills).
module enemy_manager #(
    parameter int unsigned NUM_ENEMY       = 4,
    parameter int unsigned ENEMY_HP        = 3,
    parameter int unsigned RESPAWN_FRAMES  = 120,
    parameter int unsigned ATTACK_COOLDOWN = 30
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 game_frame_clk_rising_edge,
    input  logic                 game_start,
    input  logic                 game_over,
    input  logic [NUM_ENEMY-1:0] Enemy_Hit,
    input  logic [NUM_ENEMY-1:0] Enemy_Attack_Ready,
    output logic [NUM_ENEMY-1:0] is_alive,
    output logic [NUM_ENEMY-1:0] Enemy_Is_Attacked,
    output logic                 Player_Damage,
    output logic [2:0]           Attacker_Id,
    output logic [7:0]           Kill_Count
);

    localparam int unsigned HP_W   = 4;
    localparam int unsigned TMR_W  = 8;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned KILL_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [NUM_ENEMY-1:0]            r_hit_l,    w_hit_l_next;
    logic [NUM_ENEMY-1:0]            r_alive,    w_alive_next;
    logic [NUM_ENEMY-1:0]            r_attacked, w_attacked_next;
    logic [NUM_ENEMY-1:0][HP_W-1:0]  r_hp,       w_hp_next;
    logic [NUM_ENEMY-1:0][TMR_W-1:0] r_timer,    w_timer_next;
    logic [TMR_W-1:0]                r_cooldown, w_cooldown_next;
    logic [KILL_W-1:0]               r_kill,     w_kill_next;
    logic [ID_W-1:0]                 r_rr_ptr,   w_rr_ptr_next;
    logic [ID_W-1:0]                 r_id,       w_id_next;
    logic                            r_dmg,      w_dmg_next;

    logic [NUM_ENEMY-1:0] w_hits;
    logic [NUM_ENEMY-1:0] w_hit_eff;
    logic [NUM_ENEMY-1:0] w_eligible;
    logic                 w_spawned;
    logic                 w_found;
    int unsigned          w_idx;
    logic [TMR_W-1:0]     w_respawn_load;

`ifdef ENEMY_RESPAWN_SCALE_EN
    logic [1:0]       w_shift;
    logic [TMR_W-1:0] w_scaled;

    // Respawn delay halves every 8 kills (pre-increment count), down to 1/8, never below 1
    always_comb begin
        w_shift        = (r_kill[7:3] > 5'd3) ? 2'd3 : r_kill[4:3];
        w_scaled       = TMR_W'(RESPAWN_FRAMES) >> w_shift;
        w_respawn_load = (w_scaled == '0) ? TMR_W'(1) : w_scaled;
    end
`else
    assign w_respawn_load = TMR_W'(RESPAWN_FRAMES);
`endif

    // Game state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: game_over wins over game_start
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (game_start && !game_over) w_state_next = ST_RUN;
            ST_RUN:  if (game_over)                w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Per-tick slot update: hits, timers, single spawn, attack arbitration
    always_comb begin
        w_hit_l_next    = r_hit_l;
        w_alive_next    = r_alive;
        w_attacked_next = r_attacked;
        w_hp_next       = r_hp;
        w_timer_next    = r_timer;
        w_cooldown_next = r_cooldown;
        w_kill_next     = r_kill;
        w_rr_ptr_next   = r_rr_ptr;
        w_id_next       = r_id;
        w_dmg_next      = 1'b0;
        w_hits          = r_hit_l | Enemy_Hit;
        w_hit_eff       = r_alive & w_hits;
        w_eligible      = '0;
        w_spawned       = 1'b0;
        w_found         = 1'b0;
        w_idx           = 0;

        if (r_state == ST_IDLE) begin
            w_hit_l_next = '0;
            if (w_state_next == ST_RUN) begin
                w_timer_next = '0;
                w_kill_next  = '0;
            end
        end else if (w_state_next == ST_IDLE) begin
            w_hit_l_next    = '0;
            w_alive_next    = '0;
            w_attacked_next = '0;
            w_hp_next       = '0;
            w_timer_next    = '0;
            w_cooldown_next = '0;
        end else if (game_frame_clk_rising_edge) begin
            w_hit_l_next    = '0;
            w_attacked_next = w_hit_eff;

            // Hits on live slots, countdown on dead ones, lowest ready dead slot spawns.
            // A slot killed now was alive, so it never reaches the spawn branch this tick.
            for (int i = 0; i < NUM_ENEMY; i++) begin
                if (w_hit_eff[i]) begin
                    w_hp_next[i] = r_hp[i] - HP_W'(1);
                    if (r_hp[i] == HP_W'(1)) begin
                        w_alive_next[i] = 1'b0;
                        w_timer_next[i] = w_respawn_load;
                        if (w_kill_next != 8'hFF) w_kill_next = w_kill_next + KILL_W'(1);
                    end
                end else if (!r_alive[i]) begin
                    if (r_timer[i] != '0) begin
                        w_timer_next[i] = r_timer[i] - TMR_W'(1);
                    end else if (!w_spawned) begin
                        w_spawned       = 1'b1;
                        w_alive_next[i] = 1'b1;
                        w_hp_next[i]    = HP_W'(ENEMY_HP);
                    end
                end
            end

            if (r_cooldown != '0) begin
                w_cooldown_next = r_cooldown - TMR_W'(1);
            end else begin
                w_eligible = r_alive & Enemy_Attack_Ready & ~w_hits;
                for (int unsigned k = 1; k <= NUM_ENEMY; k++) begin
                    w_idx = (32'(r_rr_ptr) + k) % NUM_ENEMY;
                    if (!w_found && w_eligible[w_idx]) begin
                        w_found         = 1'b1;
                        w_dmg_next      = 1'b1;
                        w_id_next       = ID_W'(w_idx);
                        w_rr_ptr_next   = ID_W'(w_idx);
                        w_cooldown_next = TMR_W'(ATTACK_COOLDOWN);
                    end
                end
            end
        end else begin
            w_hit_l_next = w_hits;
        end
    end

    // Slot, arbitration and score registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hit_l    <= '0;
            r_alive    <= '0;
            r_attacked <= '0;
            r_hp       <= '0;
            r_timer    <= '0;
            r_cooldown <= '0;
            r_kill     <= '0;
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_dmg      <= 1'b0;
        end else begin
            r_hit_l    <= w_hit_l_next;
            r_alive    <= w_alive_next;
            r_attacked <= w_attacked_next;
            r_hp       <= w_hp_next;
            r_timer    <= w_timer_next;
            r_cooldown <= w_cooldown_next;
            r_kill     <= w_kill_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_id       <= w_id_next;
            r_dmg      <= w_dmg_next;
        end
    end

    assign is_alive          = r_alive;
    assign Enemy_Is_Attacked = r_attacked;
    assign Player_Damage     = r_dmg;
    assign Attacker_Id       = r_id;
    assign Kill_Count        = r_kill;

endmodule

// File: tb/tb_enemy_manager.sv
// tb_enemy_manager: directed vector table plus hand sequences for enemy_manager.
module tb_enemy_manager;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       game_frame_clk_rising_edge;
    logic       game_start;
    logic       game_over;
    logic [3:0] Enemy_Hit;
    logic [3:0] Enemy_Attack_Ready;
    logic [3:0] is_alive;
    logic [3:0] Enemy_Is_Attacked;
    logic       Player_Damage;
    logic [2:0] Attacker_Id;
    logic [7:0] Kill_Count;

    int n_checks = 0;
    int n_errors = 0;

    enemy_manager dut (
        .Clk                        (Clk),
        .Reset                      (Reset),
        .game_frame_clk_rising_edge (game_frame_clk_rising_edge),
        .game_start                 (game_start),
        .game_over                  (game_over),
        .Enemy_Hit                  (Enemy_Hit),
        .Enemy_Attack_Ready         (Enemy_Attack_Ready),
        .is_alive                   (is_alive),
        .Enemy_Is_Attacked          (Enemy_Is_Attacked),
        .Player_Damage              (Player_Damage),
        .Attacker_Id                (Attacker_Id),
        .Kill_Count                 (Kill_Count)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        logic       st;
        logic       ov;
        logic       tk;
        logic [3:0] hit;
        logic [3:0] rdy;
        logic [3:0] e_alive;
        logic [3:0] e_att;
        logic       e_dmg;
        logic [2:0] e_id;
        logic [7:0] e_kill;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return just after the rising edge
    task automatic apply(input logic st, input logic ov, input logic tk,
                         input logic [3:0] h, input logic [3:0] rd);
        @(negedge Clk);
        game_start                 = st;
        game_over                  = ov;
        game_frame_clk_rising_edge = tk;
        Enemy_Hit                  = h;
        Enemy_Attack_Ready         = rd;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alive"}, 32'(is_alive), 32'h0);
        check({tag, "_att"},   32'(Enemy_Is_Attacked), 32'h0);
        check({tag, "_dmg"},   32'(Player_Damage), 32'h0);
        check({tag, "_id"},    32'(Attacker_Id), 32'h0);
        check({tag, "_kill"},  32'(Kill_Count), 32'h0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_id [4] = '{3'd1, 3'd2, 3'd3, 3'd0};

        //            st  ov  tk  hit      rdy      alive    att      dmg  id    kill
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 3'd0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 3'd0, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 1'b0, 3'd0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 1'b0, 3'd0, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 3'd0, 8'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010, 4'b1111, 4'b0010, 1'b0, 3'd0, 8'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0010, 1'b0, 3'd0, 8'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'b0010, 4'b0110, 4'b1111, 4'b0010, 1'b1, 3'd2, 8'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0010, 1'b0, 3'd2, 8'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 3'd2, 8'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b1111, 4'b0000, 1'b0, 3'd2, 8'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 1'b0, 3'd2, 8'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'b1111, 4'b0100, 1'b0, 3'd2, 8'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'b1011, 4'b0100, 1'b0, 3'd2, 8'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 1'b0, 3'd2, 8'd1};

        Reset = 1'b1;
        game_start = 1'b0; game_over = 1'b0; game_frame_clk_rising_edge = 1'b0;
        Enemy_Hit = '0; Enemy_Attack_Ready = '0;
        repeat (2) @(posedge Clk);
        #1;
        check_all_zero("reset");
        @(negedge Clk) Reset = 1'b0;

        // Ticks in IDLE do nothing
        apply(1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000);
        check("idle_tick_alive", 32'(is_alive), 32'h0);

        // Vector table: spawning, hit/ready clash, latch stickiness, kill
        for (int v = 0; v < 16; v++) begin
            apply(vecs[v].st, vecs[v].ov, vecs[v].tk, vecs[v].hit, vecs[v].rdy);
            check($sformatf("v%0d_alive", v), 32'(is_alive),          32'(vecs[v].e_alive));
            check($sformatf("v%0d_att", v),   32'(Enemy_Is_Attacked), 32'(vecs[v].e_att));
            check($sformatf("v%0d_dmg", v),   32'(Player_Damage),     32'(vecs[v].e_dmg));
            check($sformatf("v%0d_id", v),    32'(Attacker_Id),       32'(vecs[v].e_id));
            check($sformatf("v%0d_kill", v),  32'(Kill_Count),        32'(vecs[v].e_kill));
        end

        // Respawn: vecs[15] was tick 1 after the kill; ticks 2..120 keep slot 2 dead
        for (int t = 2; t <= 120; t++) begin
            apply(1'b0, 1'b0, 1'b1, (t == 50) ? 4'b0100 : 4'b0000, 4'b0000);
            if (t == 50) begin
                check("dead_hit_att",  32'(Enemy_Is_Attacked), 32'h0);
                check("dead_hit_kill", 32'(Kill_Count), 32'd1);
            end
        end
        check("pre_respawn_alive", 32'(is_alive), 32'b1011);
        apply(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
        check("respawn_alive", 32'(is_alive), 32'b1111);
        check("respawn_kill",  32'(Kill_Count), 32'd1);

        // game_over clears slots but holds the kill count
        apply(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        check("over_alive", 32'(is_alive), 32'h0);
        check("over_kill",  32'(Kill_Count), 32'd1);

        // game_start together with game_over stays in IDLE
        apply(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
        apply(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
        check("startover_alive", 32'(is_alive), 32'h0);
        check("startover_kill",  32'(Kill_Count), 32'd1);

        // Hit in IDLE is not latched; entering RUN clears the kill count
        apply(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000);
        apply(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
        check("start_kill", 32'(Kill_Count), 32'd0);
        apply(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
        apply(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
        check("run2_alive", 32'(is_alive), 32'b0011);
        check("run2_att",   32'(Enemy_Is_Attacked), 32'h0);

        // Asynchronous reset mid-RUN
        @(negedge Clk);
        game_frame_clk_rising_edge = 1'b0;
        Reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge Clk) Reset = 1'b0;
        apply(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
        check("post_rst_alive", 32'(is_alive), 32'h0);

        // Round-robin grants with cooldown, all slots alive and requesting
        apply(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
        repeat (4) apply(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
        check("rr_alive", 32'(is_alive), 32'b1111);
        for (int g = 0; g < 4; g++) begin
            apply(1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111);
            check($sformatf("grant%0d_dmg", g), 32'(Player_Damage), 32'd1);
            check($sformatf("grant%0d_id", g),  32'(Attacker_Id), 32'(exp_id[g]));
            apply(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111);
            check($sformatf("grant%0d_width", g), 32'(Player_Damage), 32'd0);
            if (g < 3) begin
                for (int c = 1; c <= 30; c++) begin
                    apply(1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111);
                    check($sformatf("cool%0d_%0d", g, c), 32'(Player_Damage), 32'd0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/enemy_manager.md
Name: enemy_manager

Overview:
Central scheduler for the NUM_ENEMY enemy instances.
- Owns each enemy's life state and hit points, and drives each instance's is_alive and Enemy_Is_Attacked inputs.
- Spawns and respawns enemies on the game frame tick.
- Arbitrates the per-enemy Enemy_Attack_Ready requests into a single rate-limited player damage event.
- Sits between the bullet/hit logic, the enemy instances and the player health logic.

Parameters:
NUM_ENEMY, 4, number of enemy slots (1..8)
ENEMY_HP, 3, hits needed to kill an enemy (1..15)
RESPAWN_FRAMES, 120, frame ticks a dead slot waits before respawning (1..255)
ATTACK_COOLDOWN, 30, frame ticks after a granted attack before the next grant is possible (0..255)

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-high reset
game_frame_clk_rising_edge  in  1  one-Clk-wide pulse, once per frame ("tick")
game_start  in  1  one-Clk pulse; enter RUN
game_over  in  1  level or pulse; return to IDLE
Enemy_Hit  in  NUM_ENEMY  per-slot hit pulse from bullet logic, any Clk cycle
Enemy_Attack_Ready  in  NUM_ENEMY  per-slot attack request from the enemy instances
is_alive  out  NUM_ENEMY  per-slot alive flag
Enemy_Is_Attacked  out  NUM_ENEMY  per-slot knockback flag
Player_Damage  out  1  one-Clk pulse per granted attack
Attacker_Id  out  3  slot index of the last grant
Kill_Count  out  8  total kills, saturating at 255

Behaviour:
Reset (async, active-high):
- State=IDLE.
- All outputs 0: is_alive, Enemy_Is_Attacked, Player_Damage, Attacker_Id, Kill_Count.
- Hit latches, HP, respawn timers, cooldown and round-robin pointer all cleared.

Hit latches:
- Enemy_Hit[i] sets sticky latch hit_l[i] on any Clk.
- All latches clear on the Clk where a tick is processed.
- A hit arriving in the same cycle as a tick is counted in that tick.

States: IDLE, RUN.
- IDLE -> RUN on game_start, provided game_over is low.
- RUN -> IDLE on game_over. game_over has priority over game_start.
- Entering IDLE clears is_alive, Enemy_Is_Attacked, HP, respawn timers and cooldown. Kill_Count is held.
- Entering RUN zeroes all respawn timers and clears Kill_Count.

All updates below occur only on a tick in RUN and are registered, so outputs change one Clk after the tick. Order of evaluation within a tick:
1. Hits: for each alive slot i with hit_l[i] set:
   - Enemy_Is_Attacked[i]=1.
   - hp[i] decrements.
   - If hp[i] was 1: is_alive[i]=0, timer[i]=RESPAWN_FRAMES, Kill_Count increments (saturates at 255).
   - Enemy_Is_Attacked[i] stays high until the next tick, then clears unless hit again.
   - Hits on dead slots are ignored.
2. Timers: for each dead slot with timer>0, timer decrements.
3. Spawn: at most one spawn per tick.
   - Candidate is the lowest-index dead slot whose timer was 0 before step 2.
   - Spawn sets is_alive=1 and hp=ENEMY_HP.
   - A slot killed in this tick cannot respawn in the same tick.
4. Attack arbitration:
   - If cooldown>0, cooldown decrements and there is no grant.
   - Otherwise eligible slots are: is_alive & Enemy_Attack_Ready & ~(hit this tick).
   - Round-robin search starts at rr_ptr+1 (mod NUM_ENEMY).
   - On a grant: Player_Damage pulses for exactly 1 Clk, Attacker_Id=winner, rr_ptr=winner, cooldown=ATTACK_COOLDOWN.
   - No eligible slot means no pulse and no state change.

General rules:
- Ticks in IDLE are ignored.
- Enemy_Hit in IDLE does not set latches.
- Counters never wrap; timers and cooldown stop at 0.

Optional Feature:
Macro ENEMY_RESPAWN_SCALE_EN.
- Defined: respawn load value is RESPAWN_FRAMES >> min(Kill_Count[7:3], 3), evaluated on the pre-increment Kill_Count. Respawn gets faster every 8 kills, down to 1/8 of the base. The load value is floored at 1.
- Undefined: load value is always RESPAWN_FRAMES, and no shifter is synthesized.

Test Plan:
1. Reset high mid-RUN with 2 alive slots -> all outputs 0 within the same cycle (async); after release, state=IDLE and ticks have no effect.
2. game_start, then 4 ticks, defaults -> is_alive = 0001, 0011, 0111, 1111, each updating 1 Clk after its tick.
3. Enemy_Hit[2] before 3 consecutive ticks -> Enemy_Is_Attacked[2] high for 3 frames; after the 3rd tick is_alive[2]=0 and Kill_Count=1; respawn occurs on tick 121 after the kill.
4. All 4 slots alive with Enemy_Attack_Ready=1111 held -> grants on ticks 0, 31, 62, 93 with Attacker_Id 1, 2, 3, 0 (rr_ptr reset 0); each Player_Damage is 1 Clk wide.
5. Enemy_Hit[1] and Attack_Ready[1] on the same tick, with Ready=0010 -> no grant; with Ready=0110 -> grant to slot 2.
6. game_start and game_over in the same cycle -> remains IDLE. With ENEMY_RESPAWN_SCALE_EN defined and Kill_Count=16 at a kill -> timer loaded 30.
